// File: rtl/cadence_pkg.sv
// ----------------------------------------------------------------------------
// cadence_pkg
// Shared definitions for the cadence period measurement block.
//   - cadence_state_e : measurement FSM states (IDLE, ARM, RUN)
//   - ST_*            : the same encodings as plain 2-bit constants, used for
//                       the state register and the debug state port
//   - PER_W/PER_SAT   : period sample width and saturation value
//   - HIST_DEPTH      : number of samples in the running average
//   - SUM_W           : running-sum width (HIST_DEPTH * PER_SAT fits in 10 bits)
// ----------------------------------------------------------------------------
package cadence_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } cadence_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ARM  = ARM;
    localparam logic [1:0] ST_RUN  = RUN;

    localparam int PER_W      = 8;
    localparam logic [PER_W-1:0] PER_SAT = 8'hFF;
    localparam int HIST_DEPTH = 4;
    localparam int SUM_W      = 10;

    // Saturating increment of a period count.
    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        logic [PER_W-1:0] r;
        r = (v == PER_SAT) ? PER_SAT : v + PER_W'(1);
        return r;
    endfunction

endpackage : cadence_pkg

// File: rtl/cadence_tick_gen.sv
// ----------------------------------------------------------------------------
// cadence_tick_gen
// Free-running prescaler that produces the period counter's time base.
// The tick is high on the cycle the prescaler is all-ones; the counter then
// wraps to zero. A synchronous clear restarts the count from zero so that a
// new period measurement starts phase-aligned with the accepted edge.
//   FAST_SIM = 1 : 8-bit prescaler,  TICK = 256 clk
//   FAST_SIM = 0 : 16-bit prescaler, TICK = 65536 clk
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   clr  in  synchronous clear to zero (wins over counting)
//   tick out one-cycle time-base strobe
// ----------------------------------------------------------------------------
module cadence_tick_gen #(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (FAST_SIM != 0) ? 8 : 16;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (clr) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = &pre_q;

endmodule : cadence_tick_gen

// File: rtl/cadence_meas.sv
// ----------------------------------------------------------------------------
// cadence_meas
// Measures the time between filtered cadence rising edges in TICK units and
// publishes the last period, a 4-sample running average, a capture strobe and
// a not-pedaling flag.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   cadence_rise in   one-cycle pulse per filtered cadence rising edge
//   cadence_per  out  last period in TICK units, saturating at 8'hFF
//   cadence_avg  out  mean of the last 4 captured periods (truncated)
//   per_vld      out  one-cycle strobe, outputs updated this cycle
//   not_pedaling out  high while the FSM is in IDLE
//   dbg_state    out  current FSM state (ST_IDLE / ST_ARM / ST_RUN)
//
// Handshake: per_vld is a pure strobe with no ready/backpressure. A consumer
// must take cadence_per/cadence_avg in the cycle per_vld is high; the values
// stay stable until the next capture or timeout.
// ----------------------------------------------------------------------------
module cadence_meas
    import cadence_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cadence_rise,
    output logic [PER_W-1:0] cadence_per,
    output logic [PER_W-1:0] cadence_avg,
    output logic             per_vld,
    output logic             not_pedaling,
    output logic [1:0]       dbg_state
);

    logic [1:0]                       state_q, state_d;
    logic [PER_W-1:0]                 per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]                 per_q, per_d;
    logic [PER_W-1:0]                 avg_q, avg_d;
    logic                             vld_q, vld_d;
    logic [HIST_DEPTH-1:0][PER_W-1:0] hist_q, hist_d;   // [0] newest, [3] oldest
    logic [SUM_W-1:0]                 sum_q, sum_d;

    logic             tick;
    logic             clr;
    logic             timeout;
    logic [PER_W-1:0] sample;

    cadence_tick_gen #(
        .FAST_SIM (FAST_SIM)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // The count as it would be after this edge. Capturing this (rather than
    // per_cnt_q) makes a rise exactly N*TICK after the previous one report N,
    // and makes a rise on the timeout cycle report the saturated value.
    assign sample  = tick ? sat_inc(per_cnt_q) : per_cnt_q;
    assign timeout = tick && (per_cnt_q == PER_SAT);

    always_comb begin
        state_d   = state_q;
        per_cnt_d = sample;
        per_d     = per_q;
        avg_d     = avg_q;
        vld_d     = 1'b0;
        hist_d    = hist_q;
        sum_d     = sum_q;
        clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counters are held at zero so the first rise starts from 0.
                clr       = 1'b1;
                per_cnt_d = '0;
                if (cadence_rise) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (cadence_rise) begin
                    // First real period: seed the whole history with it so
                    // the average is meaningful immediately.
                    state_d   = ST_RUN;
                    clr       = 1'b1;
                    per_cnt_d = '0;
                    per_d     = sample;
                    vld_d     = 1'b1;
                    hist_d    = {HIST_DEPTH{sample}};
                    sum_d     = {sample, 2'b00};
                    avg_d     = sample;
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    clr       = 1'b1;
                    per_cnt_d = '0;
                    per_d     = PER_SAT;
                    avg_d     = PER_SAT;
                    hist_d    = '0;
                    sum_d     = '0;
                end
            end

            ST_RUN: begin
                if (cadence_rise) begin
                    clr       = 1'b1;
                    per_cnt_d = '0;
                    per_d     = sample;
                    vld_d     = 1'b1;
                    hist_d    = {hist_q[HIST_DEPTH-2:0], sample};
                    sum_d     = sum_q - {2'b00, hist_q[HIST_DEPTH-1]} + {2'b00, sample};
                    avg_d     = sum_d[SUM_W-1:2];
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    clr       = 1'b1;
                    per_cnt_d = '0;
                    per_d     = PER_SAT;
                    avg_d     = PER_SAT;
                    hist_d    = '0;
                    sum_d     = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                clr       = 1'b1;
                per_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            per_q     <= PER_SAT;
            avg_q     <= PER_SAT;
            vld_q     <= 1'b0;
            hist_q    <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
            avg_q     <= avg_d;
            vld_q     <= vld_d;
            hist_q    <= hist_d;
            sum_q     <= sum_d;
        end
    end

    assign cadence_per  = per_q;
    assign cadence_avg  = avg_q;
    assign per_vld      = vld_q;
    assign not_pedaling = (state_q == ST_IDLE);
    assign dbg_state    = state_q;

endmodule : cadence_meas

// File: tb/tb_cadence_meas.sv
// ----------------------------------------------------------------------------
// tb_cadence_meas
// Directed bench for cadence_meas with FAST_SIM=1 (TICK = 256 clk).
// Two instances share clock and reset. Instance b sees the same rises as a
// once en_b is set, plus an extra rise injected through force_b; this lets
// the plain timeout and the rise-on-timeout cases share one 65536-cycle wait.
// Inputs change 1 ns after a rising edge; outputs are read there too, so a
// value read right after pulse() reflects the edge that sampled the rise.
// ----------------------------------------------------------------------------
module tb_cadence_meas;
    import cadence_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rise;
    logic       en_b;
    logic       force_b;
    logic       rise_b;

    logic [7:0] per_a, avg_a, per_b, avg_b;
    logic       vld_a, np_a, vld_b, np_b;
    logic [1:0] st_a, st_b;

    int tests = 0;
    int fails = 0;
    int vld_cnt_a = 0;
    int vld_cnt_b = 0;
    int base;

    always #5 clk = ~clk;

    assign rise_b = (rise & en_b) | force_b;

    cadence_meas #(.FAST_SIM(1)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .cadence_rise (rise),
        .cadence_per  (per_a),
        .cadence_avg  (avg_a),
        .per_vld      (vld_a),
        .not_pedaling (np_a),
        .dbg_state    (st_a)
    );

    cadence_meas #(.FAST_SIM(1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .cadence_rise (rise_b),
        .cadence_per  (per_b),
        .cadence_avg  (avg_b),
        .per_vld      (vld_b),
        .not_pedaling (np_b),
        .dbg_state    (st_b)
    );

    // per_vld strobes counted mid-cycle.
    always @(negedge clk) begin
        if (vld_a) vld_cnt_a <= vld_cnt_a + 1;
        if (vld_b) vld_cnt_b <= vld_cnt_b + 1;
    end

    // One-cycle rise, sampled by the next rising edge.
    task automatic pulse();
        rise = 1'b1;
        @(posedge clk);
        #1;
        rise = 1'b0;
    endtask

    // Rise sampled g edges after the edge that sampled the previous rise,
    // assuming the caller is still 1 ns after that edge.
    task automatic gap_rise(input int g);
        repeat (g - 1) @(posedge clk);
        #1;
        pulse();
    endtask

    task automatic test_reset();
        rst = 1'b1; rise = 1'b0; en_b = 1'b0; force_b = 1'b0;
        #3;
        tests++; if (per_a !== 8'hFF) begin fails++; $display("FAIL reset_per: got %0h expected ff", per_a); end
        tests++; if (avg_a !== 8'hFF) begin fails++; $display("FAIL reset_avg: got %0h expected ff", avg_a); end
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0b expected 0", vld_a); end
        tests++; if (np_a !== 1'b1) begin fails++; $display("FAIL reset_np: got %0b expected 1", np_a); end
        tests++; if (st_a !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", st_a, ST_IDLE); end
        tests++; if (np_b !== 1'b1) begin fails++; $display("FAIL reset_np_b: got %0b expected 1", np_b); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        repeat (2400) @(posedge clk);
        #1;
        tests++; if (per_a !== 8'hFF) begin fails++; $display("FAIL idle_per: got %0h expected ff", per_a); end
        tests++; if (avg_a !== 8'hFF) begin fails++; $display("FAIL idle_avg: got %0h expected ff", avg_a); end
        tests++; if (np_a !== 1'b1) begin fails++; $display("FAIL idle_np: got %0b expected 1", np_a); end
        tests++; if (vld_cnt_a !== 0) begin fails++; $display("FAIL idle_vld_count: got %0d expected 0", vld_cnt_a); end
    endtask

    task automatic test_first_period();
        pulse();
        tests++; if (np_a !== 1'b0) begin fails++; $display("FAIL arm_np: got %0b expected 0", np_a); end
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL arm_vld: got %0b expected 0", vld_a); end
        tests++; if (st_a !== ST_ARM) begin fails++; $display("FAIL arm_state: got %0d expected %0d", st_a, ST_ARM); end
        gap_rise(2560);
        tests++; if (vld_a !== 1'b1) begin fails++; $display("FAIL p10_vld: got %0b expected 1", vld_a); end
        tests++; if (per_a !== 8'd10) begin fails++; $display("FAIL p10_per: got %0d expected 10", per_a); end
        tests++; if (avg_a !== 8'd10) begin fails++; $display("FAIL p10_avg: got %0d expected 10", avg_a); end
        tests++; if (st_a !== ST_RUN) begin fails++; $display("FAIL p10_state: got %0d expected %0d", st_a, ST_RUN); end
        @(posedge clk);
        #1;
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL p10_vld_one_cycle: got %0b expected 0", vld_a); end
    endtask

    task automatic test_average();
        // One edge already consumed after the previous capture.
        gap_rise(5120 - 1);
        tests++; if (vld_a !== 1'b1) begin fails++; $display("FAIL p20_vld: got %0b expected 1", vld_a); end
        tests++; if (per_a !== 8'd20) begin fails++; $display("FAIL p20_per: got %0d expected 20", per_a); end
        tests++; if (avg_a !== 8'd12) begin fails++; $display("FAIL p20_avg: got %0d expected 12", avg_a); end
        // Instance b has been idle for over 10000 clocks here.
        tests++; if (per_b !== 8'hFF) begin fails++; $display("FAIL b_idle_per: got %0h expected ff", per_b); end
        tests++; if (avg_b !== 8'hFF) begin fails++; $display("FAIL b_idle_avg: got %0h expected ff", avg_b); end
        tests++; if (np_b !== 1'b1) begin fails++; $display("FAIL b_idle_np: got %0b expected 1", np_b); end
        tests++; if (vld_cnt_b !== 0) begin fails++; $display("FAIL b_idle_vld_count: got %0d expected 0", vld_cnt_b); end
        en_b = 1'b1;
        gap_rise(7680);
        tests++; if (per_a !== 8'd30) begin fails++; $display("FAIL p30_per: got %0d expected 30", per_a); end
        tests++; if (avg_a !== 8'd17) begin fails++; $display("FAIL p30_avg: got %0d expected 17", avg_a); end
        tests++; if (np_b !== 1'b0) begin fails++; $display("FAIL b_arm_np: got %0b expected 0", np_b); end
        tests++; if (vld_b !== 1'b0) begin fails++; $display("FAIL b_arm_vld: got %0b expected 0", vld_b); end
        gap_rise(10240);
        tests++; if (vld_a !== 1'b1) begin fails++; $display("FAIL p40_vld: got %0b expected 1", vld_a); end
        tests++; if (per_a !== 8'd40) begin fails++; $display("FAIL p40_per: got %0d expected 40", per_a); end
        tests++; if (avg_a !== 8'd25) begin fails++; $display("FAIL p40_avg: got %0d expected 25", avg_a); end
        tests++; if (per_b !== 8'd40) begin fails++; $display("FAIL b_p40_per: got %0d expected 40", per_b); end
        tests++; if (avg_b !== 8'd40) begin fails++; $display("FAIL b_p40_avg: got %0d expected 40", avg_b); end
        tests++; if (st_b !== ST_RUN) begin fails++; $display("FAIL b_p40_state: got %0d expected %0d", st_b, ST_RUN); end
    endtask

    task automatic test_timeout();
        @(posedge clk);
        #1;
        base = vld_cnt_a;
        // Timeout cycle is the one ending at edge capture+65536.
        repeat (65534) @(posedge clk);
        #1;
        tests++; if (np_a !== 1'b0) begin fails++; $display("FAIL pre_timeout_np: got %0b expected 0", np_a); end
        tests++; if (st_a !== ST_RUN) begin fails++; $display("FAIL pre_timeout_state: got %0d expected %0d", st_a, ST_RUN); end
        force_b = 1'b1;
        @(posedge clk);
        #1;
        force_b = 1'b0;
        tests++; if (np_a !== 1'b1) begin fails++; $display("FAIL timeout_np: got %0b expected 1", np_a); end
        tests++; if (st_a !== ST_IDLE) begin fails++; $display("FAIL timeout_state: got %0d expected %0d", st_a, ST_IDLE); end
        tests++; if (per_a !== 8'hFF) begin fails++; $display("FAIL timeout_per: got %0h expected ff", per_a); end
        tests++; if (avg_a !== 8'hFF) begin fails++; $display("FAIL timeout_avg: got %0h expected ff", avg_a); end
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL timeout_vld: got %0b expected 0", vld_a); end
        tests++; if (vld_cnt_a !== base) begin fails++; $display("FAIL timeout_vld_count: got %0d expected %0d", vld_cnt_a, base); end
        // b: rise on the timeout cycle captures the saturated count.
        tests++; if (vld_b !== 1'b1) begin fails++; $display("FAIL b_tmo_rise_vld: got %0b expected 1", vld_b); end
        tests++; if (per_b !== 8'hFF) begin fails++; $display("FAIL b_tmo_rise_per: got %0h expected ff", per_b); end
        tests++; if (avg_b !== 8'd93) begin fails++; $display("FAIL b_tmo_rise_avg: got %0d expected 93", avg_b); end
        tests++; if (np_b !== 1'b0) begin fails++; $display("FAIL b_tmo_rise_np: got %0b expected 0", np_b); end
        tests++; if (st_b !== ST_RUN) begin fails++; $display("FAIL b_tmo_rise_state: got %0d expected %0d", st_b, ST_RUN); end
    endtask

    task automatic test_back_to_back();
        pulse();
        tests++; if (st_a !== ST_ARM) begin fails++; $display("FAIL b2b1_state: got %0d expected %0d", st_a, ST_ARM); end
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL b2b1_vld_idle_rise: got %0b expected 0", vld_a); end
        tests++; if (vld_b !== 1'b1) begin fails++; $display("FAIL b2b1_vld_b: got %0b expected 1", vld_b); end
        tests++; if (per_b !== 8'd0) begin fails++; $display("FAIL b2b1_per_b: got %0d expected 0", per_b); end
        tests++; if (avg_b !== 8'd83) begin fails++; $display("FAIL b2b1_avg_b: got %0d expected 83", avg_b); end
        pulse();
        tests++; if (vld_a !== 1'b1) begin fails++; $display("FAIL b2b2_vld: got %0b expected 1", vld_a); end
        tests++; if (per_a !== 8'd0) begin fails++; $display("FAIL b2b2_per: got %0d expected 0", per_a); end
        tests++; if (avg_a !== 8'd0) begin fails++; $display("FAIL b2b2_avg: got %0d expected 0", avg_a); end
        tests++; if (st_a !== ST_RUN) begin fails++; $display("FAIL b2b2_state: got %0d expected %0d", st_a, ST_RUN); end
        tests++; if (vld_b !== 1'b1) begin fails++; $display("FAIL b2b2_vld_b: got %0b expected 1", vld_b); end
        tests++; if (per_b !== 8'd0) begin fails++; $display("FAIL b2b2_per_b: got %0d expected 0", per_b); end
        tests++; if (avg_b !== 8'd73) begin fails++; $display("FAIL b2b2_avg_b: got %0d expected 73", avg_b); end
    endtask

    task automatic test_reset_mid_arm();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse();
        tests++; if (st_a !== ST_ARM) begin fails++; $display("FAIL rarm_state: got %0d expected %0d", st_a, ST_ARM); end
        repeat (999) @(posedge clk);
        #1;
        rst = 1'b1;
        // Checked before the next edge: the reset must act asynchronously.
        #2;
        tests++; if (per_a !== 8'hFF) begin fails++; $display("FAIL rmid_per: got %0h expected ff", per_a); end
        tests++; if (avg_a !== 8'hFF) begin fails++; $display("FAIL rmid_avg: got %0h expected ff", avg_a); end
        tests++; if (np_a !== 1'b1) begin fails++; $display("FAIL rmid_np: got %0b expected 1", np_a); end
        tests++; if (vld_a !== 1'b0) begin fails++; $display("FAIL rmid_vld: got %0b expected 0", vld_a); end
        tests++; if (st_a !== ST_IDLE) begin fails++; $display("FAIL rmid_state: got %0d expected %0d", st_a, ST_IDLE); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = vld_cnt_a;
        pulse();
        tests++; if (st_a !== ST_ARM) begin fails++; $display("FAIL rearm_state: got %0d expected %0d", st_a, ST_ARM); end
        tests++; if (np_a !== 1'b0) begin fails++; $display("FAIL rearm_np: got %0b expected 0", np_a); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (vld_cnt_a !== base) begin fails++; $display("FAIL rearm_vld_count: got %0d expected %0d", vld_cnt_a, base); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_first_period();
        test_average();
        test_timeout();
        test_back_to_back();
        test_reset_mid_arm();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cadence_meas
